// File: rtl/rx_frame_sched.sv
// Frame scheduler: hunts for the header, streams the payload into the image buffer,
// checks the XOR checksum, launches the core and sends back a 2-byte reply.
module rx_frame_sched #(
  parameter int          BYTES   = 3136,
  parameter int          ADDR_W  = 12,
  parameter logic [7:0]  HDR0    = 8'hAB,
  parameter logic [7:0]  HDR1    = 8'h41,
  parameter int          TIMEOUT = 1000000
) (
  input  logic              i_clk_sys,
  input  logic              i_rst_n,
  input  logic [7:0]        i_rx_byte,
  input  logic              i_rx_done,
  output logic              o_wr_en,
  output logic [ADDR_W-1:0] o_wr_addr,
  output logic [7:0]        o_wr_data,
  output logic              o_start,
  input  logic              i_core_done,
  input  logic [3:0]        i_result,
  output logic              o_tx_start,
  output logic [7:0]        o_tx_byte,
  input  logic              i_tx_busy,
  output logic              o_busy,
  output logic              o_err
);

  localparam int CNT_W = ADDR_W + 1;
  localparam int TO_W  = $clog2(TIMEOUT + 1);
  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(BYTES - 1);
  localparam logic [TO_W-1:0]  TO_LAST  = TO_W'(TIMEOUT - 1);

  typedef enum logic [2:0] {
    IDLE, HDR, PAYLOAD, CSUM, RUN, TX0, TX1, TXW
  } state_t;

  state_t           state;
  logic [CNT_W-1:0] count;
  logic [7:0]       csum;
  logic [TO_W-1:0]  to_cnt;
  logic [3:0]       result;
  logic             skip;
  logic             second;
  logic             in_frame;
  logic             timed_out;

  // The idle watchdog only runs while a frame is being received.
  assign in_frame  = (state == HDR) || (state == PAYLOAD) || (state == CSUM);
  assign timed_out = !i_rx_done && (to_cnt == TO_LAST);
  assign o_busy    = (state != IDLE);

  always_ff @(posedge i_clk_sys) begin
    if (!i_rst_n) begin
      state      <= IDLE;
      count      <= '0;
      csum       <= '0;
      to_cnt     <= '0;
      result     <= '0;
      skip       <= 1'b0;
      second     <= 1'b0;
      o_wr_en    <= 1'b0;
      o_wr_addr  <= '0;
      o_wr_data  <= '0;
      o_start    <= 1'b0;
      o_tx_start <= 1'b0;
      o_tx_byte  <= '0;
      o_err      <= 1'b0;
    end else begin
      o_wr_en    <= 1'b0;
      o_start    <= 1'b0;
      o_tx_start <= 1'b0;
      o_err      <= 1'b0;

      if (in_frame) begin
        to_cnt <= i_rx_done ? '0 : to_cnt + 1'b1;
      end

      case (state)
        IDLE: begin
          to_cnt <= '0;
          if (i_rx_done && (i_rx_byte == HDR0)) begin
            state <= HDR;
          end
        end

        // A repeated HDR0 keeps the hunt alive so "AB AB 41" still locks.
        HDR: begin
          if (i_rx_done) begin
            if (i_rx_byte == HDR1) begin
              state <= PAYLOAD;
              count <= '0;
              csum  <= '0;
            end else if (i_rx_byte != HDR0) begin
              state <= IDLE;
            end
          end else if (timed_out) begin
            state <= IDLE;
            o_err <= 1'b1;
          end
        end

        PAYLOAD: begin
          if (i_rx_done) begin
            o_wr_en   <= 1'b1;
            o_wr_addr <= count[ADDR_W-1:0];
            o_wr_data <= i_rx_byte;
            csum      <= csum ^ i_rx_byte;
            count     <= count + 1'b1;
            if (count == LAST_IDX) begin
              state <= CSUM;
            end
          end else if (timed_out) begin
            state <= IDLE;
            o_err <= 1'b1;
          end
        end

        CSUM: begin
          if (i_rx_done) begin
            if (i_rx_byte == csum) begin
              o_start <= 1'b1;
              state   <= RUN;
            end else begin
              o_err <= 1'b1;
              state <= IDLE;
            end
          end else if (timed_out) begin
            state <= IDLE;
            o_err <= 1'b1;
          end
        end

        RUN: begin
          if (i_core_done) begin
            result <= i_result;
            state  <= TX0;
          end
        end

        TX0: begin
          if (!i_tx_busy) begin
            o_tx_start <= 1'b1;
            o_tx_byte  <= HDR0;
            skip       <= 1'b1;
            second     <= 1'b0;
            state      <= TXW;
          end
        end

        TX1: begin
          if (!i_tx_busy) begin
            o_tx_start <= 1'b1;
            o_tx_byte  <= {4'h0, result};
            skip       <= 1'b1;
            second     <= 1'b1;
            state      <= TXW;
          end
        end

        // Busy only rises the cycle after the start pulse, so ignore it for one cycle.
        TXW: begin
          if (skip) begin
            skip <= 1'b0;
          end else if (!i_tx_busy) begin
            if (second) begin
              second <= 1'b0;
              state  <= IDLE;
            end else begin
              state <= TX1;
            end
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_rx_frame_sched.sv
// Directed bench for rx_frame_sched: byte-level UART stimulus, simple core and
// transmitter models, and logs of buffer writes and reply bytes.
module tb_rx_frame_sched;

  localparam int BYTES   = 3136;
  localparam int ADDR_W  = 12;
  localparam int TIMEOUT = 50;
  localparam int LOG_N   = 32768;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic [7:0]        rx_byte = '0;
  logic              rx_done = 1'b0;
  logic              wr_en;
  logic [ADDR_W-1:0] wr_addr;
  logic [7:0]        wr_data;
  logic              start;
  logic              core_done = 1'b0;
  logic [3:0]        result = '0;
  logic              tx_start;
  logic [7:0]        tx_byte;
  logic              tx_busy;
  logic              busy;
  logic              err;

  rx_frame_sched #(
    .BYTES(BYTES), .ADDR_W(ADDR_W), .HDR0(8'hAB), .HDR1(8'h41), .TIMEOUT(TIMEOUT)
  ) dut (
    .i_clk_sys(clk), .i_rst_n(rst_n),
    .i_rx_byte(rx_byte), .i_rx_done(rx_done),
    .o_wr_en(wr_en), .o_wr_addr(wr_addr), .o_wr_data(wr_data),
    .o_start(start), .i_core_done(core_done), .i_result(result),
    .o_tx_start(tx_start), .o_tx_byte(tx_byte), .i_tx_busy(tx_busy),
    .o_busy(busy), .o_err(err)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Transmitter model: busy for 5 cycles starting the cycle after a start pulse.
  int   tx_cnt = 0;
  logic tx_hold = 1'b0;
  always @(posedge clk) begin
    if (tx_start) tx_cnt <= 5;
    else if (tx_cnt != 0) tx_cnt <= tx_cnt - 1;
  end
  assign tx_busy = (tx_cnt != 0) || tx_hold;

  logic [ADDR_W-1:0] wr_log_addr [LOG_N];
  logic [7:0]        wr_log_data [LOG_N];
  logic [7:0]        tx_log [256];
  int wr_total = 0, start_total = 0, err_total = 0, txs_total = 0;

  always @(negedge clk) begin
    if (wr_en) begin
      wr_log_addr[wr_total % LOG_N] <= wr_addr;
      wr_log_data[wr_total % LOG_N] <= wr_data;
      wr_total <= wr_total + 1;
    end
    if (start) start_total <= start_total + 1;
    if (err) err_total <= err_total + 1;
    if (tx_start) begin
      tx_log[txs_total % 256] <= tx_byte;
      txs_total <= txs_total + 1;
    end
  end

  logic [7:0] payload [BYTES];
  logic [7:0] exp_csum;

  task automatic fill(input int seed);
    logic [7:0] c = '0;
    for (int i = 0; i < BYTES; i++) begin
      payload[i] = 8'(i + seed);
      c ^= payload[i];
    end
    exp_csum = c;
  endtask

  // Caller is always sitting on a falling edge; back-to-back calls give one byte per cycle.
  task automatic applyStimulus(input logic [7:0] b);
    rx_byte = b;
    rx_done = 1'b1;
    @(negedge clk);
    rx_done = 1'b0;
  endtask

  task automatic pulse_core(input logic [3:0] r);
    result = r;
    core_done = 1'b1;
    @(negedge clk);
    core_done = 1'b0;
  endtask

  task automatic send_frame(input int gap_at, input int gap_len, input logic [7:0] flip);
    applyStimulus(8'hAB);
    applyStimulus(8'h41);
    for (int i = 0; i < BYTES; i++) begin
      applyStimulus(payload[i]);
      if (i == gap_at) repeat (gap_len) @(negedge clk);
    end
    applyStimulus(exp_csum ^ flip);
  endtask

  task automatic check_frame(input int base, input int n);
    checkOutput("wr_count", wr_total - base, n);
    for (int i = 0; i < n; i++) begin
      int e0 = errors;
      checkOutput("wr_addr", 32'(wr_log_addr[(base + i) % LOG_N]), i);
      checkOutput("wr_data", 32'(wr_log_data[(base + i) % LOG_N]), 32'(payload[i]));
      if (errors != e0) break;
    end
  endtask

  task automatic wait_idle(input int max);
    int n = 0;
    while (busy && n < max) begin
      @(negedge clk);
      n++;
    end
    checkOutput("idle_wait_expired", 32'(n >= max), 0);
  endtask

  task automatic check_reset_outputs(input string tag);
    checkOutput({tag, "_wr_en"}, wr_en, 0);
    checkOutput({tag, "_wr_addr"}, wr_addr, 0);
    checkOutput({tag, "_wr_data"}, wr_data, 0);
    checkOutput({tag, "_start"}, start, 0);
    checkOutput({tag, "_tx_start"}, tx_start, 0);
    checkOutput({tag, "_tx_byte"}, tx_byte, 0);
    checkOutput({tag, "_busy"}, busy, 0);
    checkOutput({tag, "_err"}, err, 0);
  endtask

  task automatic run_good_frame(input int seed, input logic [3:0] r, input int gap_at, input int gap_len);
    int base, s0, e0, t0;
    fill(seed);
    base = wr_total; s0 = start_total; e0 = err_total; t0 = txs_total;
    send_frame(gap_at, gap_len, 8'h00);
    repeat (3) @(negedge clk);
    check_frame(base, BYTES);
    checkOutput("start_pulse", start_total - s0, 1);
    checkOutput("busy_run", busy, 1);
    pulse_core(r);
    wait_idle(400);
    checkOutput("tx_count", txs_total - t0, 2);
    checkOutput("tx_byte0", tx_log[t0 % 256], 8'hAB);
    checkOutput("tx_byte1", tx_log[(t0 + 1) % 256], {4'h0, r});
    checkOutput("err_none", err_total - e0, 0);
  endtask

  initial begin
    #900000;
    $display("[TB] FAIL watchdog: simulation did not finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int base, s0, e0, t0, w1, n;

    repeat (3) @(negedge clk);
    check_reset_outputs("reset");
    rst_n = 1'b1;
    @(negedge clk);

    $display("[TB] T1 nominal frame");
    run_good_frame(0, 4'h7, -1, 0);

    $display("[TB] T2 bad checksum");
    fill(5);
    base = wr_total; s0 = start_total; e0 = err_total;
    send_frame(-1, 0, 8'h01);
    repeat (3) @(negedge clk);
    checkOutput("bad_csum_writes", wr_total - base, BYTES);
    checkOutput("bad_csum_err", err_total - e0, 1);
    checkOutput("bad_csum_start", start_total - s0, 0);
    checkOutput("bad_csum_busy", busy, 0);
    run_good_frame(9, 4'h2, -1, 0);

    $display("[TB] T3 header resync");
    applyStimulus(8'h12);
    applyStimulus(8'hAB);
    run_good_frame(21, 4'h5, -1, 0);
    base = wr_total; e0 = err_total;
    applyStimulus(8'hAB);
    applyStimulus(8'h13);
    for (int i = 0; i < 20; i++) applyStimulus(8'(i));
    repeat (3) @(negedge clk);
    checkOutput("bad_hdr_writes", wr_total - base, 0);
    checkOutput("bad_hdr_busy", busy, 0);
    checkOutput("bad_hdr_err", err_total - e0, 0);
    run_good_frame(40, 4'hA, 100, TIMEOUT - 1);

    $display("[TB] T4 timeout");
    fill(33);
    base = wr_total; s0 = start_total; e0 = err_total;
    applyStimulus(8'hAB);
    applyStimulus(8'h41);
    for (int i = 0; i < 10; i++) applyStimulus(payload[i]);
    repeat (3) @(negedge clk);
    check_frame(base, 10);
    n = 0;
    while (err_total == e0 && n < 200) begin
      @(negedge clk);
      n++;
    end
    @(negedge clk);
    checkOutput("timeout_err", err_total - e0, 1);
    checkOutput("timeout_busy", busy, 0);
    checkOutput("timeout_start", start_total - s0, 0);
    run_good_frame(50, 4'h1, -1, 0);

    $display("[TB] T5 busy ignore");
    t0 = txs_total;
    pulse_core(4'hE);
    repeat (3) @(negedge clk);
    checkOutput("idle_core_busy", busy, 0);
    fill(77);
    base = wr_total; s0 = start_total;
    send_frame(-1, 0, 8'h00);
    repeat (3) @(negedge clk);
    check_frame(base, BYTES);
    checkOutput("t5_start", start_total - s0, 1);
    w1 = wr_total;
    applyStimulus(8'hAB);
    applyStimulus(8'h41);
    applyStimulus(8'h01);
    applyStimulus(8'h02);
    repeat (3) @(negedge clk);
    checkOutput("run_rx_writes", wr_total - w1, 0);
    checkOutput("run_busy", busy, 1);
    tx_hold = 1'b1;
    pulse_core(4'h3);
    repeat (20) @(negedge clk);
    checkOutput("tx_wait_hold", txs_total - t0, 0);
    checkOutput("tx_hold_busy", busy, 1);
    tx_hold = 1'b0;
    n = 0;
    while (txs_total == t0 && n < 50) begin
      @(negedge clk);
      n++;
    end
    checkOutput("tx_first_seen", txs_total - t0, 1);
    checkOutput("tx_byte_stable", tx_byte, 8'hAB);
    applyStimulus(8'hAB);
    applyStimulus(8'h41);
    pulse_core(4'h9);
    wait_idle(200);
    checkOutput("t5_tx_count", txs_total - t0, 2);
    checkOutput("t5_tx_byte0", tx_log[t0 % 256], 8'hAB);
    checkOutput("t5_tx_byte1", tx_log[(t0 + 1) % 256], 8'h03);
    checkOutput("t5_no_writes", wr_total - w1, 0);

    $display("[TB] T6 reset mid-payload");
    fill(90);
    base = wr_total;
    applyStimulus(8'hAB);
    applyStimulus(8'h41);
    for (int i = 0; i < 100; i++) applyStimulus(payload[i]);
    repeat (2) @(negedge clk);
    check_frame(base, 100);
    rst_n = 1'b0;
    @(negedge clk);
    check_reset_outputs("midrst");
    rst_n = 1'b1;
    @(negedge clk);
    run_good_frame(123, 4'hC, -1, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
